ky32_imem_loader: RTL

//  Byte-stream program loader for kythera32: writing end of the instruction memory

---
 rtl/ky32_imem_loader_if.sv | 20 ++
 rtl/ky32_imem_loader.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ky32_imem_loader_if.sv
// Byte link and imem write port of the kythera32 program loader.
// The loader takes the slave view; the byte source and imem take the master view.
interface ky32_imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/ky32_imem_loader.sv
// Framed byte-stream loader for the kythera32 instruction memory.
// It holds the CPU in reset until a frame with a good XOR checksum has been written.
module ky32_imem_loader #(
  parameter int         DEPTH = 256,
  parameter logic [7:0] MAGIC = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  ky32_imem_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);

  localparam int          IW      = $clog2(DEPTH + 1);
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  state_t         state_r, state_next;
  logic [15:0]    len_r;
  logic [IW-1:0]  idx_r;
  logic [1:0]     bi_r;
  logic [7:0]     xor_r;
  logic [23:0]    word_r;
  logic           rx_ready_r, im_we_r;
  logic [31:0]    im_addr_r, im_wdata_r;
  logic           hold_r, done_r, err_r;
  logic           hold_s, done_s, err_s;
  logic           acc_s, last_word_s;
  logic [15:0]    len_s;
  logic [7:0]     b_s;

  assign b_s         = bus.rx_data;
  assign acc_s       = bus.rx_valid & rx_ready_r;
  assign len_s       = {b_s, len_r[7:0]};
  assign last_word_s = (16'(idx_r) + 16'd1) == len_r;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state decode, evaluated only on an accepted byte
  always_comb begin
    state_next = state_r;
    if (acc_s) begin
      case (state_r)
        ST_IDLE: state_next = (b_s == MAGIC) ? ST_LEN0 : ST_IDLE;
        ST_LEN0: state_next = ST_LEN1;
        ST_LEN1: begin
          if (len_s > DEPTH_W) begin
            state_next = ST_ERR;
          end else if (len_s == 16'd0) begin
            state_next = ST_CSUM;
          end else begin
            state_next = ST_DATA;
          end
        end
        ST_DATA: state_next = (bi_r == 2'd3 && last_word_s) ? ST_CSUM : ST_DATA;
        ST_CSUM: state_next = (b_s == xor_r) ? ST_DONE : ST_ERR;
        ST_DONE: state_next = (b_s == MAGIC) ? ST_LEN0 : ST_DONE;
        ST_ERR:  state_next = (b_s == MAGIC) ? ST_LEN0 : ST_ERR;
        default: state_next = ST_IDLE;
      endcase
    end else begin
      state_next = state_r;
    end
  end

  // Status outputs follow the state being entered so they line up with it
  always_comb begin
    done_s = 1'b0;
    err_s  = 1'b0;
    hold_s = 1'b1;
    case (state_next)
      ST_DONE: begin done_s = 1'b1; hold_s = 1'b0; end
      ST_ERR:  err_s = 1'b1;
      default: hold_s = 1'b1;
    endcase
  end

  // Datapath: length latch, word assembly, checksum and the imem write strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready_r <= 1'b0;
      im_we_r    <= 1'b0;
      im_addr_r  <= 32'd0;
      im_wdata_r <= 32'd0;
      hold_r     <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      len_r      <= 16'd0;
      idx_r      <= '0;
      bi_r       <= 2'd0;
      xor_r      <= 8'd0;
      word_r     <= 24'd0;
    end else begin
      rx_ready_r <= 1'b1;
      im_we_r    <= 1'b0;
      hold_r     <= hold_s;
      done_r     <= done_s;
      err_r      <= err_s;
      if (acc_s) begin
        case (state_r)
          ST_LEN0: len_r[7:0] <= b_s;
          ST_LEN1: begin
            len_r[15:8] <= b_s;
            idx_r       <= '0;
            bi_r        <= 2'd0;
            xor_r       <= 8'd0;
          end
          ST_DATA: begin
            xor_r <= xor_r ^ b_s;
            bi_r  <= bi_r + 2'd1;
            case (bi_r)
              2'd0: word_r[7:0]   <= b_s;
              2'd1: word_r[15:8]  <= b_s;
              2'd2: word_r[23:16] <= b_s;
              default: begin
                im_we_r    <= 1'b1;
                im_addr_r  <= 32'(idx_r) << 2;
                im_wdata_r <= {b_s, word_r};
                idx_r      <= idx_r + IW'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready = rx_ready_r;
  assign bus.im_we    = im_we_r;
  assign bus.im_addr  = im_addr_r;
  assign bus.im_wdata = im_wdata_r;
  assign cpu_hold     = hold_r;
  assign done         = done_r;
  assign err          = err_r;

endmodule
